// File: rtl/mash_ncn_pkg.sv
// Shared constants and helpers for the MASH noise-cancellation network.
// Sizing rules and the divide-word clamp live here.
package mash_ncn_pkg;

   localparam int LP_STAGES = 4;

   function automatic int ofs_width(input int stages);
      return stages + 1;
   endfunction

   function automatic int latency(input int stages);
      return stages;
   endfunction

   function automatic int fill_max(input int stages);
      return 2 * stages - 1;
   endfunction

   function automatic int clamp_int(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/mash_ncn_diff.sv
// One differentiator level of the recombiner: d = c + d_next - h.
// h is d_next from the previous enabled cycle, cleared on order change.
module mash_ncn_diff
   import mash_ncn_pkg::*;
#(
   parameter int P_W = ofs_width(LP_STAGES)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_en,
   input  logic                  i_clr,
   input  logic                  i_c,
   input  logic signed [P_W-1:0] i_d,
   output logic signed [P_W-1:0] o_d
);

   logic signed [P_W-1:0] r_h;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_h <= '0;
      end else if (i_en) begin
         r_h <= i_clr ? '0 : i_d;
      end
   end

   assign o_d = i_d - r_h + P_W'(i_c);

endmodule

// File: rtl/mash_ncn.sv
// MASH recombiner: deskews per-stage carries, forms sum (1-z^-1)^k c_k,
// and adds the signed offset to the integer divide word with clamping.
module mash_ncn
   import mash_ncn_pkg::*;
#(
   parameter int P_STAGES    = LP_STAGES,
   parameter int P_OFS_WIDTH = ofs_width(P_STAGES),
   parameter int P_INT_WIDTH = 8
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_en,
   input  logic [3:0]                    i_order,
   input  logic [P_STAGES-1:0]           i_carry,
   input  logic [P_INT_WIDTH-1:0]        i_int,
   output logic signed [P_OFS_WIDTH-1:0] o_offset,
   output logic [P_INT_WIDTH-1:0]        o_div,
   output logic                          o_valid
);

   localparam int LP_LAT  = latency(P_STAGES);
   localparam int LP_FILL = fill_max(P_STAGES);
   localparam int LP_FW   = $clog2(LP_FILL + 1);
   localparam int LP_DMAX = (1 << P_INT_WIDTH) - 1;

   logic [3:0]                    w_ord;
   logic                          w_chg;
   logic [P_STAGES-1:0]           w_al;
   logic [P_STAGES-1:0]           w_c;
   logic signed [P_OFS_WIDTH-1:0] w_d [P_STAGES];
   logic signed [P_OFS_WIDTH-1:0] w_d0;
   int                            w_sum;

   logic [3:0]       r_ord;
   logic             r_primed;
   logic [LP_FW-1:0] r_fill;

   assign w_ord = (i_order > 4'(P_STAGES)) ? 4'(P_STAGES) : i_order;
   // The registered order is meaningless until the first enabled cycle.
   assign w_chg = r_primed && (w_ord != r_ord);

   for (genvar k = 0; k < P_STAGES; k++) begin : g_dsk
      localparam int LP_D = LP_LAT - 1 - k;
      if (LP_D == 0) begin : g_thru
         assign w_al[k] = i_carry[k];
      end else begin : g_reg
         logic [LP_D-1:0] r_sh;
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               r_sh <= '0;
            end else if (i_en) begin
               r_sh <= (r_sh << 1) | LP_D'(i_carry[k]);
            end
         end
         assign w_al[k] = r_sh[LP_D-1];
      end
      assign w_c[k] = w_al[k] & (4'(k) < w_ord);
   end

   assign w_d[P_STAGES-1] = P_OFS_WIDTH'(w_c[P_STAGES-1]);

   for (genvar k = 0; k < P_STAGES - 1; k++) begin : g_lvl
      mash_ncn_diff #(
         .P_W (P_OFS_WIDTH)
      ) u_diff (
         .i_clk (i_clk),
         .i_rst (i_rst),
         .i_en  (i_en),
         .i_clr (w_chg),
         .i_c   (w_c[k]),
         .i_d   (w_d[k+1]),
         .o_d   (w_d[k])
      );
   end

   assign w_d0  = (w_ord == 4'd0) ? '0 : w_d[0];
   assign w_sum = int'(i_int) + int'(w_d0);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_offset <= '0;
         o_div    <= '0;
         r_ord    <= '0;
         r_primed <= 1'b0;
         r_fill   <= '0;
      end else if (i_en) begin
         o_offset <= w_d0;
         o_div    <= P_INT_WIDTH'(clamp_int(w_sum, 0, LP_DMAX));
         r_ord    <= w_ord;
         r_primed <= 1'b1;
         if (w_chg) begin
            r_fill <= '0;
         end else if (r_fill != LP_FW'(LP_FILL)) begin
            r_fill <= r_fill + 1'b1;
         end
      end
   end

   assign o_valid = (r_fill == LP_FW'(LP_FILL));

endmodule

// File: tb/tb_mash_ncn.sv
// Scoreboard bench for mash_ncn: aligned samples feed a binomial-sum model,
// a negedge monitor pops expectations on every enabled output cycle.
module tb_mash_ncn;

   localparam int P     = 4;
   localparam int OW    = 5;
   localparam int IW    = 8;
   localparam int FILLM = 2 * P - 1;
   localparam int DMAX  = (1 << IW) - 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 en;
   logic [3:0]           ord;
   logic [P-1:0]         carry;
   logic [IW-1:0]        intv;
   logic signed [OW-1:0] offset;
   logic [IW-1:0]        div;
   logic                 valid;

   mash_ncn #(
      .P_STAGES    (P),
      .P_OFS_WIDTH (OW),
      .P_INT_WIDTH (IW)
   ) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_en     (en),
      .i_order  (ord),
      .i_carry  (carry),
      .i_int    (intv),
      .o_offset (offset),
      .o_div    (div),
      .o_valid  (valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit known;
      int y;
      int dv;
   } exp_t;

   exp_t         sbq[$];
   exp_t         mx;
   int           checks = 0;
   int           errors = 0;
   logic [P-1:0] s_arr [0:8191];
   int           t;
   int           mcnt;
   int           mord;
   bit           primed;
   bit           clean;
   int           cur_ord;

   function automatic int binom(input int n, input int k);
      int r = 1;
      for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
      return r;
   endfunction

   // y[n] = sum_{k<m} sum_{j<=k} (-1)^j C(k,j) a_k[n-j], zero history before n=0
   function automatic int model_y(input int n, input int m);
      int y = 0;
      for (int k = 0; k < m; k++)
         for (int j = 0; j <= k; j++)
            if (n - j >= 0 && s_arr[n-j][k])
               y += ((j % 2) != 0) ? -binom(k, j) : binom(k, j);
      return y;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      t      = 0;
      mcnt   = 0;
      primed = 0;
      clean  = 1;
      sbq.delete();
   endtask

   task automatic step(input bit e, input logic [3:0] o,
                       input logic [P-1:0] samp, input logic [IW-1:0] iv);
      int   m;
      int   v;
      exp_t x;
      en   = e;
      ord  = o;
      intv = iv;
      if (e) begin
         m = (int'(o) > P) ? P : int'(o);
         s_arr[t] = samp;
         for (int k = 0; k < P; k++)
            carry[k] = (t - k >= 0) ? s_arr[t-k][k] : 1'b0;
         if (primed && m != mord) begin
            mcnt  = 0;
            clean = 0;
         end else if (mcnt < FILLM) begin
            mcnt++;
         end
         primed  = 1;
         mord    = m;
         x.known = clean || (mcnt == FILLM);
         x.y     = model_y(t - P + 1, m);
         v       = int'(iv) + x.y;
         x.dv    = (v < 0) ? 0 : ((v > DMAX) ? DMAX : v);
         sbq.push_back(x);
         t++;
      end else begin
         carry = P'($urandom);
      end
      @(posedge clk);
      #1;
      chk("valid", int'(valid), int'(mcnt == FILLM));
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_offset", int'(offset), 0);
      chk("rst_div", int'(div), 0);
      chk("rst_valid", int'(valid), 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   bit                   en_q  = 1'b0;
   bit                   rst_q = 1'b1;
   logic signed [OW-1:0] p_off;
   logic [IW-1:0]        p_div;
   logic                 p_val;

   always @(posedge clk) begin
      en_q  = en;
      rst_q = rst;
   end

   always @(negedge clk) begin
      if (!rst_q) begin
         if (en_q) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_empty: output with no expectation at %0t", $time);
            end else begin
               mx = sbq.pop_front();
               if (mx.known) begin
                  chk("offset", int'(offset), mx.y);
                  chk("div", int'(div), mx.dv);
               end
            end
         end else begin
            chk("hold_offset", int'(offset), int'(p_off));
            chk("hold_div", int'(div), int'(p_div));
            chk("hold_valid", int'(valid), int'(p_val));
         end
      end
      p_off = offset;
      p_div = div;
      p_val = valid;
   end

   logic [3:0] pat1;

   initial begin
      rst   = 1'b1;
      en    = 1'b0;
      ord   = '0;
      carry = '0;
      intv  = '0;
      pat1  = 4'b1101;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("init_offset", int'(offset), 0);
      chk("init_div", int'(div), 0);
      chk("init_valid", int'(valid), 0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++)
         step(1, 4'd1, (i < 4) ? {3'b000, pat1[i]} : 4'b0, 8'd20);

      for (int i = 0; i < 12; i++) step(1, 4'd2, 4'b0010, IW'($urandom));
      for (int i = 0; i < 3; i++) step(1, 4'd2, 4'b0000, 8'd50);
      step(1, 4'd2, 4'b0010, 8'd50);
      for (int i = 0; i < 8; i++) step(1, 4'd2, 4'b0000, 8'd50);

      for (int i = 0; i < 10; i++) step(1, 4'd4, 4'b0000, 8'd100);
      step(1, 4'd4, 4'b1000, 8'd100);
      for (int i = 0; i < 8; i++) step(1, 4'd4, 4'b0000, 8'd100);

      for (int i = 0; i < 10; i++) step(1, 4'd4, (i % 2 == 0) ? 4'hF : 4'h0, 8'd255);
      for (int i = 0; i < 10; i++) step(1, 4'd4, (i % 2 == 0) ? 4'hF : 4'h0, 8'd3);

      for (int i = 0; i < 6; i++) step(1, 4'd4, P'($urandom), IW'($urandom));
      for (int i = 0; i < 5; i++) step(0, 4'd4, P'($urandom), IW'($urandom));
      for (int i = 0; i < 8; i++) step(1, 4'd4, P'($urandom), IW'($urandom));

      for (int i = 0; i < 10; i++) step(1, 4'd2, P'($urandom), IW'($urandom));

      do_reset();
      for (int i = 0; i < 10; i++) step(1, 4'd3, P'($urandom), IW'($urandom));

      cur_ord = 4;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) cur_ord = $urandom_range(0, 9);
         if ($urandom_range(0, 199) == 0) do_reset();
         step($urandom_range(0, 9) != 0, 4'(cur_ord), P'($urandom), IW'($urandom));
      end

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
